// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU operation scheduler.
// The ALU itself lives outside the scheduler.
package alu_sched_pkg;

   localparam int WIDTH_DEF = 5;
   localparam int OPW_DEF   = 3;
   localparam int SHW_DEF   = 2;
   localparam int CNTW_DEF  = 8;

   // Bit positions inside the {N,Z,C,V} flag nibble
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } sched_state_e;

endpackage

// File: rtl/alu_op_scheduler_rr_arb2.sv
// Two-way round-robin grant. Purely combinational; the parent keeps last_grant.
// A lone valid requester always wins; on a tie the one not granted last time wins.
module rr_arb2 (
   input  logic [1:0] valid_i,
   input  logic       last_grant_i,
   output logic [1:0] grant_o
);

   assign grant_o[0] = valid_i[0] & (~valid_i[1] | last_grant_i);
   assign grant_o[1] = valid_i[1] & (~valid_i[0] | ~last_grant_i);

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one external combinational ALU between two requesters: round-robin
// accept, one execute cycle, then a tagged response held until consumed.
module alu_op_scheduler
   import alu_sched_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int OPW   = OPW_DEF,
   parameter int SHW   = SHW_DEF,
   parameter int CNTW  = CNTW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req0_op,
   input  logic [SHW-1:0]   req0_shift,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OPW-1:0]   req1_op,
   input  logic [SHW-1:0]   req1_shift,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_control,
   output logic [SHW-1:0]   alu_bshift,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [3:0]       alu_flags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic [3:0]       rsp_flags,
   output logic             busy,
   output logic [CNTW-1:0]  op_count
);

   sched_state_e     state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [OPW-1:0]   alu_op_q, alu_op_d;
   logic [SHW-1:0]   alu_sh_q, alu_sh_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic [3:0]       rsp_flags_q, rsp_flags_d;
   logic [CNTW-1:0]  op_count_q, op_count_d;
   logic [1:0]       grant;

   rr_arb2 u_arb (
      .valid_i      ({req1_valid, req0_valid}),
      .last_grant_i (last_grant_q),
      .grant_o      (grant)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      alu_sh_d     = alu_sh_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      op_count_d   = op_count_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;

      case (state_q)
         IDLE: begin
            req0_ready = grant[0];
            req1_ready = grant[1];
            if (|grant) begin
               // The tag is latched here; rsp_valid stays low until it matters
               alu_a_d      = grant[1] ? req1_a     : req0_a;
               alu_b_d      = grant[1] ? req1_b     : req0_b;
               alu_op_d     = grant[1] ? req1_op    : req0_op;
               alu_sh_d     = grant[1] ? req1_shift : req0_shift;
               rsp_id_d     = grant[1];
               last_grant_d = grant[1];
               state_d      = EXEC;
            end
         end
         EXEC: begin
            rsp_result_d = alu_result;
            rsp_flags_d  = alu_flags;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               op_count_d  = op_count_q + CNTW'(1);
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         alu_sh_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         op_count_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         alu_sh_q     <= alu_sh_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         op_count_q   <= op_count_d;
      end
   end

   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_control = alu_op_q;
   assign alu_bshift  = alu_sh_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_flags   = rsp_flags_q;
   assign busy        = (state_q != IDLE);
   assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: a behavioural ALU closes the loop, and a
// transaction-level model predicts handshakes, responses and the op counter.
module tb_alu_op_scheduler;

   localparam int WIDTH = 5;
   localparam int OPW   = 3;
   localparam int SHW   = 2;
   localparam int CNTW  = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [OPW-1:0]   req0_op, req1_op;
   logic [SHW-1:0]   req0_shift, req1_shift;
   logic [WIDTH-1:0] alu_a, alu_b, alu_result;
   logic [OPW-1:0]   alu_control;
   logic [SHW-1:0]   alu_bshift;
   logic [3:0]       alu_flags;
   logic             rsp_valid, rsp_ready, rsp_id, busy;
   logic [WIDTH-1:0] rsp_result;
   logic [3:0]       rsp_flags;
   logic [CNTW-1:0]  op_count;

   always #5 clk = ~clk;

   alu_op_scheduler #(.WIDTH(WIDTH), .OPW(OPW), .SHW(SHW), .CNTW(CNTW)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
      .req0_b(req0_b), .req0_op(req0_op), .req0_shift(req0_shift),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
      .req1_b(req1_b), .req1_op(req1_op), .req1_shift(req1_shift),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .alu_bshift(alu_bshift), .alu_result(alu_result), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy),
      .op_count(op_count)
   );

   // Stand-in ALU: returns {Result, N, Z, C, V}; C on subtract is a borrow
   function automatic logic [WIDTH+3:0] alu_fn(input logic [WIDTH-1:0] a, b,
                                               input logic [OPW-1:0] op);
      logic [WIDTH:0]   s;
      logic [WIDTH-1:0] r;
      logic             c, v;
      s = '0; c = 1'b0; v = 1'b0;
      case (op)
         3'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[WIDTH-1:0];
            c = s[WIDTH];
            v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         3'd1: begin
            r = a - b;
            c = (a < b);
            v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         3'd2:    r = a & b;
         3'd3:    r = a | b;
         default: r = a ^ b;
      endcase
      return {r, r[WIDTH-1], (r == '0), c, v};
   endfunction

   always_comb {alu_result, alu_flags} = alu_fn(alu_a, alu_b, alu_control);

   int ncmp = 0;
   int nfail = 0;

   // Model state: one op in flight at most, cycles since its accept, grant history
   logic             m_inflight;
   int               m_age;
   logic             m_last;
   int               m_cnt;
   int               m_done;
   logic             m_id;
   logic [WIDTH-1:0] m_a, m_b;
   logic [OPW-1:0]   m_op;
   logic [SHW-1:0]   m_sh;
   logic             order_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_inflight = 1'b0; m_age = 0; m_last = 1'b1; m_cnt = 0; m_done = 0;
      m_id = 1'b0; m_a = '0; m_b = '0; m_op = '0; m_sh = '0;
   endtask

   // Check one cycle against the model, then advance across one rising edge
   task automatic tick();
      logic er0, er1, ersp;
      logic [WIDTH+3:0] ex;
      #1;
      ersp = m_inflight && (m_age >= 1);
      er0  = !m_inflight && req0_valid && (!req1_valid || m_last);
      er1  = !m_inflight && req1_valid && (!req0_valid || !m_last);
      ex   = alu_fn(m_a, m_b, m_op);
      chk("req0_ready", 32'(req0_ready), 32'(er0));
      chk("req1_ready", 32'(req1_ready), 32'(er1));
      chk("busy", 32'(busy), 32'(m_inflight));
      chk("rsp_valid", 32'(rsp_valid), 32'(ersp));
      chk("op_count", 32'(op_count), 32'(m_cnt % 256));
      chk("alu_a", 32'(alu_a), 32'(m_a));
      chk("alu_b", 32'(alu_b), 32'(m_b));
      chk("alu_control", 32'(alu_control), 32'(m_op));
      chk("alu_bshift", 32'(alu_bshift), 32'(m_sh));
      if (ersp) begin
         chk("rsp_id", 32'(rsp_id), 32'(m_id));
         chk("rsp_result", 32'(rsp_result), 32'(ex[WIDTH+3:4]));
         chk("rsp_flags", 32'(rsp_flags), 32'(ex[3:0]));
      end
      if (reset) model_reset();
      else if (ersp && rsp_ready) begin
         m_inflight = 1'b0; m_cnt++; m_done++;
      end else if (m_inflight) m_age++;
      else if (er0 || er1) begin
         m_inflight = 1'b1; m_age = 0; m_id = er1; m_last = er1;
         m_a  = er1 ? req1_a : req0_a;
         m_b  = er1 ? req1_b : req0_b;
         m_op = er1 ? req1_op : req0_op;
         m_sh = er1 ? req1_shift : req0_shift;
         order_q.push_back(er1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_ops();
      req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom); req0_op = OPW'($urandom_range(0, 4));
      req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); req1_op = OPW'($urandom_range(0, 4));
   endtask

   initial begin
      int snap;
      int cyc;
      reset = 1'b1; rsp_ready = 1'b0;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0; req0_shift = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0; req1_shift = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      chk("reset rsp_valid", 32'(rsp_valid), 0);
      chk("reset op_count", 32'(op_count), 0);
      chk("reset busy", 32'(busy), 0);
      chk("reset alu_a", 32'(alu_a), 0);
      chk("reset rsp_result", 32'(rsp_result), 0);

      // Single add from requester 0
      req0_valid = 1'b1; req0_a = 5'd3; req0_b = 5'd5; req0_op = 3'b000; rsp_ready = 1'b1;
      #1;
      chk("t1 req0_ready", 32'(req0_ready), 1);
      tick();
      req0_valid = 1'b0;
      tick();
      chk("t1 rsp_valid", 32'(rsp_valid), 1);
      chk("t1 rsp_id", 32'(rsp_id), 0);
      chk("t1 rsp_result", 32'(rsp_result), 8);
      chk("t1 rsp_flags", 32'(rsp_flags), 0);
      tick();
      chk("t1 op_count", 32'(op_count), 1);

      // Subtract to zero from requester 1
      req1_valid = 1'b1; req1_a = 5'd5; req1_b = 5'd5; req1_op = 3'b001;
      tick();
      req1_valid = 1'b0;
      tick();
      chk("t2 rsp_id", 32'(rsp_id), 1);
      chk("t2 rsp_result", 32'(rsp_result), 0);
      chk("t2 rsp_flags", 32'(rsp_flags), 32'h4);
      tick();

      // Both requesters valid continuously: grants must alternate
      order_q.delete();
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 40 && order_q.size() < 4; i++) begin
         rand_ops();
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("fair count", 32'(order_q.size()), 4);
      for (int i = 0; i < 4 && i < order_q.size(); i++)
         chk("fair order", 32'(order_q[i]), 32'(i % 2));
      for (int i = 0; i < 10 && m_inflight; i++) tick();

      // Consumer stall with a one-cycle valid pulse while busy
      req0_valid = 1'b1; req0_a = 5'd7; req0_b = 5'd2; req0_op = 3'b001; rsp_ready = 1'b0;
      tick();
      req0_valid = 1'b0;
      tick();
      snap = m_cnt;
      for (int i = 0; i < 5; i++) begin
         req0_valid = (i == 0) || (i == 2);
         req1_valid = (i == 2);
         tick();
         chk("stall op_count", 32'(op_count), 32'(snap % 256));
         chk("stall rsp_result", 32'(rsp_result), 5);
      end
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      tick();
      chk("stall release op_count", 32'(op_count), 32'((snap + 1) % 256));
      repeat (3) tick();

      // Reset while the op is in EXEC
      req0_valid = 1'b1; req0_a = 5'd9; req0_b = 5'd4; req0_op = 3'b000;
      tick();
      req0_valid = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst rsp_valid", 32'(rsp_valid), 0);
      chk("rst alu_a", 32'(alu_a), 0);
      chk("rst alu_b", 32'(alu_b), 0);
      chk("rst alu_control", 32'(alu_control), 0);
      chk("rst op_count", 32'(op_count), 0);
      chk("rst busy", 32'(busy), 0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("rst tie req0_ready", 32'(req0_ready), 1);
      chk("rst tie req1_ready", 32'(req1_ready), 0);

      // Random traffic until 256 responses have been consumed since reset
      cyc = 0;
      while (m_done < 256 && cyc < 20000) begin
         tick();
         rand_ops();
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 2) != 0);
         rsp_ready  = ($urandom_range(0, 3) != 0);
         cyc++;
      end
      chk("wrap done", 32'(m_done), 256);
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      chk("wrap op_count", 32'(op_count), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
Shares one combinational ALU (operands a/b, ALUControl, bshift in; Result, ALUFlags out) between two requesters.
- Round-robin arbitration over valid/ready request channels.
- Registers the winning operation and drives the ALU from those registers.
- Captures Result/ALUFlags one cycle later and returns them on a single tagged response channel.
- Sits between the sequencing logic and the ALU top; the ALU is instantiated outside this block.

Parameters:
WIDTH, 5, operand/result width (matches ALU a, b, Result)
OPW, 3, ALUControl width
SHW, 2, bshift width
CNTW, 8, completed-operation counter width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle (when valid)
req0_a  in  WIDTH  operand a
req0_b  in  WIDTH  operand b
req0_op  in  OPW  ALUControl code
req0_shift  in  SHW  bshift code
req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_shift: same as requester 0, for requester 1
alu_a  out  WIDTH  to ALU a
alu_b  out  WIDTH  to ALU b
alu_control  out  OPW  to ALU ALUControl
alu_bshift  out  SHW  to ALU bshift
alu_result  in  WIDTH  from ALU Result
alu_flags  in  4  from ALU ALUFlags {N,Z,C,V}
rsp_valid  out  1  response available
rsp_ready  in  1  consumer takes response
rsp_id  out  1  requester that issued the op
rsp_result  out  WIDTH  captured Result
rsp_flags  out  4  captured ALUFlags
busy  out  1  high in EXEC or RESP
op_count  out  CNTW  completed responses, wraps

Behaviour:
- Reset (sync, reset=1 at clk edge):
  - state=IDLE; alu_a/alu_b/alu_control/alu_bshift=0.
  - rsp_valid=0; rsp_id/rsp_result/rsp_flags=0.
  - op_count=0; last_grant=1 so requester 0 wins the first tie.
  - Reset mid-operation discards the in-flight op; nothing is emitted.
- FSM states:
  - IDLE: reqN_ready is combinational. Only the granted requester's ready is high, and only if its valid is high. At most one ready is high per cycle.
    - Grant: the single valid requester wins. If both are valid, the requester not equal to last_grant wins.
    - On a transfer (valid&ready): latch a/b/op/shift into the alu_* registers, latch id, set last_grant=id, go to EXEC.
    - No valid requester: stay in IDLE.
  - EXEC: one cycle. alu_* are stable, and the ALU settles combinationally. At the clock edge, capture alu_result/alu_flags into rsp_result/rsp_flags, set rsp_valid=1, go to RESP.
  - RESP: rsp_* held stable while rsp_valid=1 && rsp_ready=0.
    - On rsp_ready=1: rsp_valid=0, op_count+1 (2^CNTW-1 wraps to 0), go to IDLE.
    - No new accept occurs in the cycle the response is consumed.
- Both reqN_ready are 0 outside IDLE.
- Latency: accept at edge T → rsp_valid=1 after edge T+1. Minimum 3 cycles per op (accept, exec, consume).
- alu_* hold the last issued op until the next accept (not cleared on return to IDLE).
- A requester may drop valid before acceptance with no side effect. Operands are sampled only at the transfer edge.
- Fairness: with both valid continuously, grants alternate 0,1,0,1...
- rsp_ready high while rsp_valid=0 is ignored.

Decomposition:
- Package alu_sched_pkg:
  - state enum {IDLE, EXEC, RESP};
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - ALUControl codes OP_ADD=3'b000, OP_SUB=3'b001;
  - default widths.
- Sub-module rr_arb2: 2-way round-robin grant (inputs: valid[1:0], last_grant; output: grant one-hot). Combinational. The last_grant register lives in the parent.

Test Plan:
(Bench instantiates the ALU top connected to alu_*/alu_result/alu_flags; shift=0 throughout.)
1. req0 a=3, b=5, op=000; rsp_ready=1 → req0_ready=1 in the accept cycle; rsp_valid two edges later with rsp_id=0, rsp_result=8, rsp_flags=4'b0000; op_count=1.
2. req1 a=5, b=5, op=001 → rsp_id=1, rsp_result=0, rsp_flags Z=1 (4'b0100).
3. Both valid continuously for 4 ops, rsp_ready=1 → accept order 0,1,0,1; each response tagged to the issuing requester with its correct result.
4. rsp_ready=0 for 5 cycles after rsp_valid → rsp_result/flags/id stable, both reqN_ready=0, busy=1; op_count increments only on the cycle rsp_ready rises.
5. Assert reset during EXEC → next cycle state=IDLE, rsp_valid=0, alu_*=0, op_count=0; the following tie is granted to req0.
6. Run 256 completed ops → op_count wraps to 0. req0 valid pulsed for 1 cycle while busy → never accepted, no response.
